// File: rtl/vote_logger_if.sv
// Bundles the logger's mode select, raw push-buttons and result outputs.
// The master side drives mode and the buttons. The slave side is the logger.
interface vote_logger_if;
   logic       mode;
   logic       candidate1_button;
   logic       candidate2_button;
   logic       candidate3_button;
   logic [6:0] candidate1_vote;
   logic [6:0] candidate2_vote;
   logic [6:0] candidate3_vote;
   logic       valid_vote_casted;
   logic       vote_rejected;

   modport master (
      output mode,
      output candidate1_button,
      output candidate2_button,
      output candidate3_button,
      input  candidate1_vote,
      input  candidate2_vote,
      input  candidate3_vote,
      input  valid_vote_casted,
      input  vote_rejected
   );

   modport slave (
      input  mode,
      input  candidate1_button,
      input  candidate2_button,
      input  candidate3_button,
      output candidate1_vote,
      output candidate2_vote,
      output candidate3_vote,
      output valid_vote_casted,
      output vote_rejected
   );
endinterface

// File: rtl/vote_logger.sv
// Three-candidate vote logger.
// Each raw button passes through a 2-flop synchronizer. The synchronized
// vector is then debounced. One stable single press casts one vote for that
// candidate, and each candidate's count saturates at MAX_VOTES. Pressing two
// or more buttons at once, or pressing for a saturated candidate, is refused
// with a one-cycle vote_rejected pulse. While mode is 1 (result mode), the
// counts are frozen and every press is ignored.
module vote_logger #(
   parameter int unsigned DEBOUNCE_CYCLES = 4,
   parameter int unsigned MAX_VOTES       = 99
) (
   input  logic          clock,
   input  logic          reset,
   vote_logger_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE,
      DEBOUNCE,
      CAST,
      WAIT_RELEASE
   } state_t;

   localparam logic [7:0] DB_LIMIT   = 8'(DEBOUNCE_CYCLES);
   localparam logic [6:0] VOTE_LIMIT = 7'(MAX_VOTES);

   logic [2:0] meta_q;
   logic [2:0] sync_q;
   state_t     state_q;
   logic [7:0] stable_q;
   logic [2:0] sel_q;
   logic [6:0] c1_q;
   logic [6:0] c2_q;
   logic [6:0] c3_q;
   logic       valid_q;
   logic       rej_q;

   logic [2:0] raw_d;
   logic [6:0] sel_count_d;
   logic       one_hot_d;

   assign raw_d     = {bus.candidate3_button, bus.candidate2_button, bus.candidate1_button};
   assign one_hot_d = $onehot(sync_q);

   // Current total of the latched candidate, used for the saturation check
   always_comb begin
      sel_count_d = c3_q;
      if (sel_q[0]) begin
         sel_count_d = c1_q;
      end else if (sel_q[1]) begin
         sel_count_d = c2_q;
      end
   end

   // Two-flop synchronizer for the asynchronous push-buttons
   always_ff @(posedge clock) begin
      if (!reset) begin
         meta_q <= 3'b000;
         sync_q <= 3'b000;
      end else begin
         meta_q <= raw_d;
         sync_q <= meta_q;
      end
   end

   // Press FSM with registered counts and pulses; mode overrides every transition
   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q  <= IDLE;
         stable_q <= 8'd0;
         sel_q    <= 3'b000;
         c1_q     <= 7'd0;
         c2_q     <= 7'd0;
         c3_q     <= 7'd0;
         valid_q  <= 1'b0;
         rej_q    <= 1'b0;
      end else begin
         valid_q <= 1'b0;
         rej_q   <= 1'b0;
         if (bus.mode) begin
            state_q <= WAIT_RELEASE;
         end else begin
            case (state_q)
               IDLE: begin
                  if (one_hot_d) begin
                     sel_q    <= sync_q;
                     stable_q <= 8'd1;
                     state_q  <= DEBOUNCE;
                  end else if (sync_q != 3'b000) begin
                     rej_q   <= 1'b1;
                     state_q <= WAIT_RELEASE;
                  end
               end
               DEBOUNCE: begin
                  if (sync_q == sel_q) begin
                     stable_q <= stable_q + 8'd1;
                     if (stable_q + 8'd1 == DB_LIMIT) begin
                        state_q <= CAST;
                     end
                  end else begin
                     state_q <= IDLE;
                  end
               end
               CAST: begin
                  if (sel_count_d < VOTE_LIMIT) begin
                     valid_q <= 1'b1;
                     if (sel_q[0]) begin
                        c1_q <= c1_q + 7'd1;
                     end else if (sel_q[1]) begin
                        c2_q <= c2_q + 7'd1;
                     end else begin
                        c3_q <= c3_q + 7'd1;
                     end
                  end else begin
                     rej_q <= 1'b1;
                  end
                  state_q <= WAIT_RELEASE;
               end
               WAIT_RELEASE: begin
                  if (sync_q == 3'b000) begin
                     state_q <= IDLE;
                  end
               end
               default: state_q <= IDLE;
            endcase
         end
      end
   end

   assign bus.candidate1_vote   = c1_q;
   assign bus.candidate2_vote   = c2_q;
   assign bus.candidate3_vote   = c3_q;
   assign bus.valid_vote_casted = valid_q;
   assign bus.vote_rejected     = rej_q;

endmodule

// File: tb/tb_vote_logger.sv
// Testbench for vote_logger. A press-tracking model runs alongside the DUT,
// and directed scenarios add hand-computed totals and latencies.
module tb_vote_logger;

   localparam int DB  = 4;
   localparam int MAXV = 99;

   logic clock;
   logic reset;
   vote_logger_if vif ();

   vote_logger #(
      .DEBOUNCE_CYCLES(DB),
      .MAX_VOTES(MAXV)
   ) dut (
      .clock(clock),
      .reset(reset),
      .bus(vif)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int checks   = 0;
   int failures = 0;
   bit go = 1'b0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // raw buttons delayed by two clocks; a press is "armed" once all buttons
   // are released in voting mode; run counts consecutive stable sightings.
   int         m_cnt [3];
   bit         m_valid, m_rej;
   bit         armed;
   bit         pend;
   int         run;
   logic [2:0] cand;
   logic [2:0] s1, s2, v;

   always @(posedge clock) begin
      v = s2;
      m_valid = 1'b0;
      m_rej   = 1'b0;
      if (!reset) begin
         for (int i = 0; i < 3; i++) m_cnt[i] = 0;
         s1 = 3'b000; s2 = 3'b000;
         armed = 1'b1; pend = 1'b0; run = 0; cand = 3'b000;
      end else begin
         s2 = s1;
         s1 = {vif.candidate3_button, vif.candidate2_button, vif.candidate1_button};
         if (vif.mode) begin
            armed = 1'b0; pend = 1'b0; run = 0;
         end else if (pend) begin
            for (int i = 0; i < 3; i++) begin
               if (cand[i]) begin
                  if (m_cnt[i] < MAXV) begin
                     m_cnt[i]++;
                     m_valid = 1'b1;
                  end else begin
                     m_rej = 1'b1;
                  end
               end
            end
            pend = 1'b0; armed = 1'b0;
         end else if (!armed) begin
            if (v == 3'b000) armed = 1'b1;
         end else if (run == 0) begin
            if ($countones(v) == 1) begin
               cand = v; run = 1;
            end else if (v != 3'b000) begin
               m_rej = 1'b1; armed = 1'b0;
            end
         end else begin
            if (v == cand) begin
               run++;
               if (run == DB) begin
                  pend = 1'b1; run = 0;
               end
            end else begin
               run = 0;
            end
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   int valid_total = 0;
   int rej_total   = 0;

   always @(negedge clock) begin
      if (go) begin
         chk("c1_vote", int'(vif.candidate1_vote), m_cnt[0]);
         chk("c2_vote", int'(vif.candidate2_vote), m_cnt[1]);
         chk("c3_vote", int'(vif.candidate3_vote), m_cnt[2]);
         chk("valid_pulse", int'(vif.valid_vote_casted), int'(m_valid));
         chk("reject_pulse", int'(vif.vote_rejected), int'(m_rej));
         chk("pulse_exclusive", int'(vif.valid_vote_casted & vif.vote_rejected), 0);
         valid_total += int'(vif.valid_vote_casted);
         rej_total   += int'(vif.vote_rejected);
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic set_btn(input logic [2:0] m);
      vif.candidate1_button = m[0];
      vif.candidate2_button = m[1];
      vif.candidate3_button = m[2];
   endtask

   task automatic press(input logic [2:0] m, input int hold, input int rel);
      set_btn(m);
      tick(hold);
      set_btn(3'b000);
      tick(rel);
   endtask

   int v0, r0;

   initial begin
      reset = 1'b0;
      vif.mode = 1'b0;
      set_btn(3'b000);
      tick(1);
      go = 1'b1;
      tick(1);
      chk("reset_c1", int'(vif.candidate1_vote), 0);
      chk("reset_c2", int'(vif.candidate2_vote), 0);
      chk("reset_c3", int'(vif.candidate3_vote), 0);
      chk("reset_valid", int'(vif.valid_vote_casted), 0);
      chk("reset_reject", int'(vif.vote_rejected), 0);
      reset = 1'b1;
      tick(2);

      // candidate2 held 20 cycles: count changes exactly at edge 7
      v0 = valid_total; r0 = rej_total;
      set_btn(3'b010);
      tick(6);
      chk("lat_c2_before_edge7", int'(vif.candidate2_vote), 0);
      tick(1);
      chk("lat_c2_after_edge7", int'(vif.candidate2_vote), 1);
      chk("lat_valid_edge7", int'(vif.valid_vote_casted), 1);
      tick(13);
      set_btn(3'b000);
      tick(5);
      chk("hold_one_pulse", valid_total - v0, 1);
      chk("hold_c1_zero", int'(vif.candidate1_vote), 0);
      chk("hold_c3_zero", int'(vif.candidate3_vote), 0);

      // short bounces on candidate1
      v0 = valid_total; r0 = rej_total;
      for (int i = 0; i < 3; i++) press(3'b001, 2, 4);
      chk("bounce_c1", int'(vif.candidate1_vote), 0);
      chk("bounce_pulses", (valid_total - v0) + (rej_total - r0), 0);

      // candidate1 and candidate3 together, then candidate3 alone
      v0 = valid_total; r0 = rej_total;
      press(3'b101, 3, 4);
      chk("multi_reject", rej_total - r0, 1);
      chk("multi_c1", int'(vif.candidate1_vote), 0);
      chk("multi_c3", int'(vif.candidate3_vote), 0);
      press(3'b100, 10, 5);
      chk("after_multi_c3", int'(vif.candidate3_vote), 1);

      // 101 presses of candidate1 saturate at 99
      v0 = valid_total; r0 = rej_total;
      for (int i = 0; i < 101; i++) press(3'b001, 8, 4);
      chk("sat_c1", int'(vif.candidate1_vote), 99);
      chk("sat_valid", valid_total - v0, 99);
      chk("sat_reject", rej_total - r0, 2);

      // mode toggled mid-debounce while held
      v0 = valid_total; r0 = rej_total;
      set_btn(3'b010);
      tick(4);
      vif.mode = 1'b1;
      tick(3);
      vif.mode = 1'b0;
      tick(10);
      chk("mode_abort_c2", int'(vif.candidate2_vote), 1);
      chk("mode_abort_pulses", (valid_total - v0) + (rej_total - r0), 0);
      set_btn(3'b000);
      tick(4);
      press(3'b010, 8, 4);
      chk("mode_repress_c2", int'(vif.candidate2_vote), 2);

      // bring candidate3 to 5, then reset with a press pending
      for (int i = 0; i < 4; i++) press(3'b100, 8, 4);
      chk("pre_reset_c3", int'(vif.candidate3_vote), 5);
      set_btn(3'b010);
      tick(5);
      reset = 1'b0;
      tick(1);
      chk("rst_c1", int'(vif.candidate1_vote), 0);
      chk("rst_c2", int'(vif.candidate2_vote), 0);
      chk("rst_c3", int'(vif.candidate3_vote), 0);
      reset = 1'b1;
      tick(10);
      set_btn(3'b000);
      tick(4);
      chk("held_through_reset_c2", int'(vif.candidate2_vote), 1);
      press(3'b001, 8, 4);
      chk("resume_c1", int'(vif.candidate1_vote), 1);
      chk("resume_c3", int'(vif.candidate3_vote), 0);

      go = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/vote_logger.md
VOTE_LOGGER -- requirements
Module: vote_logger

Interface
REQ-001 Parameter: DEBOUNCE_CYCLES, default 4, consecutive synchronized cycles a single button must be stable before a vote is cast (legal range 2..255).
REQ-002 Parameter: MAX_VOTES, default 99, saturation limit per candidate; must fit the 7-bit count and the two-digit display.
REQ-003 Port: clock  input  1  single system clock; all state updates on its rising edge.
REQ-004 Port: reset  input  1  synchronous, active-low reset; sampled only on the rising edge of clock.
REQ-005 Port: mode  input  1  0 = voting mode, 1 = result mode.
REQ-006 Port: candidate1_button, candidate2_button, candidate3_button  input  1 each  raw, asynchronous push-buttons, active-high.
REQ-007 Port: candidate1_vote, candidate2_vote, candidate3_vote  output  7 each  registered per-candidate vote totals.
REQ-008 Port: valid_vote_casted  output  1  registered one-cycle pulse per counted vote.
REQ-009 Port: vote_rejected  output  1  registered one-cycle pulse per refused press (multi-button press or saturated candidate).

Function
REQ-010 Each raw button SHALL pass a 2-flop synchronizer; "button vector" below means the 3-bit synchronized output.
REQ-011 FSM states SHALL be IDLE, DEBOUNCE, CAST and WAIT_RELEASE, plus an 8-bit stability counter and a latched 3-bit candidate select.
REQ-012 IDLE, vector == 000: SHALL remain in IDLE.
REQ-013 IDLE, vector one-hot: SHALL latch the vector, set counter = 1 and go to DEBOUNCE.
REQ-014 IDLE, two or more bits set: SHALL pulse vote_rejected and go to WAIT_RELEASE.
REQ-015 DEBOUNCE, vector equals the latched select: SHALL increment the counter.
REQ-016 DEBOUNCE, counter reaches DEBOUNCE_CYCLES: SHALL go to CAST.
REQ-017 DEBOUNCE, vector differs from the latched select: SHALL return to IDLE with no pulse and no count change.
REQ-018 CAST, selected count < MAX_VOTES: SHALL increment that count by 1 and pulse valid_vote_casted on the same edge.
REQ-019 CAST, selected count == MAX_VOTES: SHALL leave all counts unchanged and pulse vote_rejected.
REQ-020 CAST SHALL always go to WAIT_RELEASE in one cycle, regardless of which branch applied.
REQ-021 WAIT_RELEASE SHALL go to IDLE only when vector == 000 and mode == 0, so a held button yields exactly one vote.
REQ-022 Latency: for a button held from the first edge its synchronized value is high, valid_vote_casted and the updated count SHALL appear after rising edge DEBOUNCE_CYCLES+3.
REQ-023 valid_vote_casted and vote_rejected SHALL each be high for exactly one cycle per event and SHALL never be high together.
REQ-024 mode == 1 SHALL force WAIT_RELEASE from any state, aborting any debounce or cast in progress with no count change and no pulse.
REQ-025 Counts SHALL persist across mode changes, since the result stage reads them in mode 1.
REQ-026 At most one count SHALL change per cycle.
REQ-027 No count SHALL ever exceed MAX_VOTES or wrap around.
REQ-028 Priority SHALL be reset > mode > FSM transitions.

Reset
REQ-029 reset == 0 at a rising edge SHALL clear all counts, synchronizers, the stability counter, the latched select and both pulse outputs to 0, and SHALL set the FSM to IDLE.
REQ-030 Reset asserted mid-DEBOUNCE or in CAST SHALL discard the pending vote.
REQ-031 After reset deasserts, a button still held SHALL be treated as a new press.

Verification
REQ-032 Bench: DEBOUNCE_CYCLES=4, mode=0, candidate2_button held 20 cycles -> candidate2_vote 0->1 after edge 7, exactly one valid_vote_casted pulse, other counts 0.
REQ-033 Bench: candidate1 pressed 2 cycles then released, 3 repetitions -> no pulses, candidate1_vote stays 0.
REQ-034 Bench: candidate1 and candidate3 pressed together -> one vote_rejected pulse, all counts 0; after both release, candidate3 alone -> candidate3_vote = 1.
REQ-035 Bench: 101 separate presses of candidate1 -> candidate1_vote = 99, 99 valid pulses, 2 vote_rejected pulses.
REQ-036 Bench: mode switched 0->1 mid-DEBOUNCE with button held, then back to 0 while still held -> no vote until the button is released and pressed again.
REQ-037 Bench: reset driven low for 1 cycle at count 5, then high -> all counts 0 at the next edge; counting resumes normally afterwards.
